// File: rtl/lag_meter_if.sv
// -----------------------------------------------------------------------------
// lag_meter_if
//   Result stream from lag_meter to the reporting/OSD logic.
//
//   Handshake: a word moves on a rising clock edge where result_valid and
//   result_ready are both high. While result_valid is high and result_ready is
//   low, the producer holds result_channel/result_cycles/result_timeout and
//   result_valid steady. result_valid never drops without a transfer, except
//   on reset.
//
//   Signals:
//     result_valid   : producer has a word
//     result_ready   : consumer accepts the word
//     result_channel : sensor channel the word belongs to
//     result_cycles  : measured lag in clocks
//     result_timeout : channel never confirmed before the timeout
//
//   Modports: master = lag_meter side, slave = consumer side.
// -----------------------------------------------------------------------------
interface lag_meter_if #(
  parameter int COUNTER_WIDTH = 24
);
  logic                     result_valid;
  logic                     result_ready;
  logic [2:0]               result_channel;
  logic [COUNTER_WIDTH-1:0] result_cycles;
  logic                     result_timeout;

  modport master (
    output result_valid,
    output result_channel,
    output result_cycles,
    output result_timeout,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_channel,
    input  result_cycles,
    input  result_timeout,
    output result_ready
  );
endinterface

// File: rtl/lag_meter.sv
// -----------------------------------------------------------------------------
// lag_meter
//   Multi-channel input-lag measurement engine. A start pulse marks the first
//   pixel of the flash frame; each photo-sensor channel is timed to its first
//   debounced rising edge and one result word per channel is then streamed
//   out in channel order.
//
//   Ports:
//     clock, reset_n : pixel clock, asynchronous active-low reset
//     start          : one-cycle pulse, accepted only in IDLE
//     sensor         : raw asynchronous sensor inputs
//     busy           : high while measuring or reporting
//     led            : debounced synchronised level per channel
//     dbg_state      : current FSM state (IDLE=0, MEASURE=1, REPORT=2)
//     res            : result stream (lag_meter_if.master)
//
//   Optional feature: define LAG_METER_AVERAGE_EN to average 2^AVG_LOG2
//   measurement runs per report. Without it no accumulator logic exists.
// -----------------------------------------------------------------------------
module lag_meter #(
  parameter int          CHANNELS        = 2,
  parameter int          COUNTER_WIDTH   = 24,
  parameter int unsigned MAX_CYCLES      = 24'hFFFFFF,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          AVG_LOG2        = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CHANNELS-1:0] sensor,
  output logic                busy,
  output logic [CHANNELS-1:0] led,
  output logic [1:0]          dbg_state,
  lag_meter_if.master         res
);

  if (CHANNELS < 1 || CHANNELS > 8 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      AVG_LOG2 < 0 || 64'(MAX_CYCLES) >= (64'd1 << COUNTER_WIDTH)) begin : g_param_check
    $error("lag_meter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_REPORT  = 2'd2
  } state_e;

  localparam int DW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [DW-1:0]            DEB_FULL = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]            DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] MAX_C    = COUNTER_WIDTH'(MAX_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] SYNC_LAT = COUNTER_WIDTH'(SYNC_STAGES - 1);
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(CHANNELS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

  logic [SYNC_STAGES-1:0]   sync_q [CHANNELS];
  logic [SYNC_STAGES-1:0]   sync_d [CHANNELS];
  logic [DW-1:0]            hi_q   [CHANNELS];
  logic [DW-1:0]            hi_d   [CHANNELS];
  logic [COUNTER_WIDTH-1:0] cap_q  [CHANNELS];
  logic [COUNTER_WIDTH-1:0] cap_d  [CHANNELS];

  logic [CHANNELS-1:0]      lvl;
  logic [CHANNELS-1:0]      led_q, led_d;
  logic [CHANNELS-1:0]      armed_q, armed_d;
  logic [CHANNELS-1:0]      pend_q, pend_d;
  logic [CHANNELS-1:0]      done_q, done_d;
  logic [CHANNELS-1:0]      to_q, to_d;

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;
  logic [2:0]               chan_q, chan_d;
  logic [COUNTER_WIDTH-1:0] cycles_q, cycles_d;
  logic                     timeout_q, timeout_d;

  logic                     timed_out;
  logic                     measure_exit;
  logic                     enter_report;

`ifdef LAG_METER_AVERAGE_EN
  localparam int                SUM_W     = COUNTER_WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2:0] RUNS_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0]    sum_q [CHANNELS];
  logic [SUM_W-1:0]    sum_d [CHANNELS];
  logic [CHANNELS-1:0] tacc_q, tacc_d;
  logic [AVG_LOG2:0]   run_q, run_d;
`endif

  // Level seen by the measurement logic is the last synchroniser stage.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      lvl[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    led_d        = led_q;
    armed_d      = armed_q;
    pend_d       = pend_q;
    done_d       = done_q;
    to_d         = to_q;
    idx_d        = idx_q;
    nxt_idx      = idx_q + 1'b1;
    busy_d       = busy_q;
    valid_d      = valid_q;
    chan_d       = chan_q;
    cycles_d     = cycles_q;
    timeout_d    = timeout_q;
    timed_out    = 1'b0;
    measure_exit = 1'b0;
    enter_report = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], sensor[c]};
      cap_d[c]  = cap_q[c];
      // Run length of consecutive high samples, saturating at DEBOUNCE_CYCLES.
      if (!lvl[c])                hi_d[c] = '0;
      else if (hi_q[c] == DEB_FULL) hi_d[c] = hi_q[c];
      else                        hi_d[c] = hi_q[c] + 1'b1;
      led_d[c] = (hi_d[c] == DEB_FULL);
    end
`ifdef LAG_METER_AVERAGE_EN
    tacc_d = tacc_q;
    run_d  = run_q;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_d[c] = sum_q[c];
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
          armed_d = '0;
          pend_d  = '0;
          done_d  = '0;
          to_d    = '0;
          busy_d  = 1'b1;
`ifdef LAG_METER_AVERAGE_EN
          // Only the first run of a batch clears the accumulators.
          if (run_q == '0) begin
            tacc_d = '0;
            for (int c = 0; c < CHANNELS; c++) begin
              sum_d[c] = '0;
            end
          end
`endif
        end
      end

      S_MEASURE: begin
        if (cnt_q != MAX_C) cnt_d = cnt_q + 1'b1;
        timed_out = (cnt_q == MAX_C);

        for (int c = 0; c < CHANNELS; c++) begin
          if (!done_q[c]) begin
            if (!armed_q[c]) begin
              // A channel must see low first so a stuck-high sensor times out.
              if (!lvl[c]) armed_d[c] = 1'b1;
            end else if (!pend_q[c]) begin
              if (lvl[c]) begin
                // Rising edge: back out the synchroniser latency so the value
                // is referred to the edge where stage 1 first sampled high.
                pend_d[c] = 1'b1;
                cap_d[c]  = (cnt_q >= SYNC_LAT) ? (cnt_q - SYNC_LAT) : '0;
                if (hi_q[c] == DEB_LAST) begin
                  pend_d[c] = 1'b0;
                  done_d[c] = 1'b1;
                end
              end
            end else begin
              if (!lvl[c]) begin
                pend_d[c] = 1'b0;          // glitch: drop candidate, stay armed
              end else if (hi_q[c] == DEB_LAST) begin
                pend_d[c] = 1'b0;
                done_d[c] = 1'b1;
              end
            end
          end
        end

        measure_exit = (&done_d) || timed_out;

        if (measure_exit) begin
          // Confirmations from this same cycle are already in done_d, so a
          // simultaneous confirm beats the timeout.
          for (int c = 0; c < CHANNELS; c++) begin
            if (!done_d[c]) begin
              cap_d[c]  = MAX_C;
              to_d[c]   = 1'b1;
              pend_d[c] = 1'b0;
            end
          end
`ifdef LAG_METER_AVERAGE_EN
          for (int c = 0; c < CHANNELS; c++) begin
            sum_d[c]  = sum_q[c] + SUM_W'(cap_d[c]);
            tacc_d[c] = tacc_q[c] | to_d[c];
          end
          if (run_q == RUNS_LAST) begin
            for (int c = 0; c < CHANNELS; c++) begin
              cap_d[c] = COUNTER_WIDTH'(sum_d[c] >> AVG_LOG2);
              to_d[c]  = tacc_d[c];
            end
            run_d        = '0;
            enter_report = 1'b1;
          end else begin
            // Gap between runs: IDLE with busy held high.
            run_d   = run_q + 1'b1;
            state_d = S_IDLE;
          end
`else
          enter_report = 1'b1;
`endif
        end

        if (enter_report) begin
          state_d   = S_REPORT;
          idx_d     = '0;
          valid_d   = 1'b1;
          chan_d    = 3'd0;
          cycles_d  = cap_d[0];
          timeout_d = to_d[0];
        end
      end

      S_REPORT: begin
        // result_valid is always high in REPORT; a word moves when ready is high.
        if (res.result_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            valid_d   = 1'b0;
            chan_d    = 3'd0;
            cycles_d  = '0;
            timeout_d = 1'b0;
          end else begin
            idx_d     = nxt_idx;
            chan_d    = 3'(nxt_idx);
            cycles_d  = cap_q[nxt_idx];
            timeout_d = to_q[nxt_idx];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      led_q     <= '0;
      armed_q   <= '0;
      pend_q    <= '0;
      done_q    <= '0;
      to_q      <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      chan_q    <= 3'd0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= '0;
        hi_q[c]   <= '0;
        cap_q[c]  <= '0;
      end
`ifdef LAG_METER_AVERAGE_EN
      tacc_q <= '0;
      run_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= '0;
      end
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      armed_q   <= armed_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      to_q      <= to_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      chan_q    <= chan_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= sync_d[c];
        hi_q[c]   <= hi_d[c];
        cap_q[c]  <= cap_d[c];
      end
`ifdef LAG_METER_AVERAGE_EN
      tacc_q <= tacc_d;
      run_q  <= run_d;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= sum_d[c];
      end
`endif
    end
  end

  assign busy               = busy_q;
  assign led                = led_q;
  assign dbg_state          = state_q;
  assign res.result_valid   = valid_q;
  assign res.result_channel = chan_q;
  assign res.result_cycles  = cycles_q;
  assign res.result_timeout = timeout_q;

endmodule

// File: tb/tb_lag_meter.sv
// -----------------------------------------------------------------------------
// tb_lag_meter
//   Directed scenarios for lag_meter with CHANNELS=2, SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4, MAX_CYCLES=1000. Expected words are pushed into
//   exp_q when a scenario is set up; the monitor pops and compares every
//   transferred word and checks that a stalled word holds steady.
//   Inputs change on the falling edge; "slot s" is the falling edge just
//   before rising edge E_s, where E_0 is the edge that accepts start.
// -----------------------------------------------------------------------------
module tb_lag_meter;
  localparam int CH   = 2;
  localparam int CW   = 24;
  localparam int MAXC = 1000;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef LAG_METER_AVERAGE_EN
  localparam int AVG  = 2;
`else
  localparam int AVG  = 3;
`endif
  localparam int W     = 3 + 1 + CW;
  localparam int NEVER = 1 << 20;

  // ---------------- clock / reset ----------------
  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic [CH-1:0] sensor  = '0;
  logic          busy;
  logic [CH-1:0] led;
  logic [1:0]    dbg_state;

  lag_meter_if #(.COUNTER_WIDTH(CW)) rif ();

  lag_meter #(
    .CHANNELS       (CH),
    .COUNTER_WIDTH  (CW),
    .MAX_CYCLES     (MAXC),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .AVG_LOG2       (AVG)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .sensor   (sensor),
    .busy     (busy),
    .led      (led),
    .dbg_state(dbg_state),
    .res      (rif.master)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [W-1:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int cyc, input bit to);
    exp_q.push_back({3'(ch), to, CW'(cyc)});
  endtask

  // ---------------- monitor ----------------
  logic         held_v = 1'b0;
  logic [W-1:0] held_w;
  logic [W-1:0] mon_w;
  logic [W-1:0] mon_e;

  always begin
    @(negedge clock);
    #3;
    if (reset_n && rif.result_valid) begin
      mon_w = {rif.result_channel, rif.result_timeout, rif.result_cycles};
      if (held_v) check("hold_while_stalled", 32'(mon_w), 32'(held_w));
      if (rif.result_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got ch=%0d cycles=%0d to=%0d, expected none",
                   rif.result_channel, rif.result_cycles, rif.result_timeout);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_channel", 32'(mon_w[W-1 -: 3]), 32'(mon_e[W-1 -: 3]));
          check("word_cycles",  32'(mon_w[CW-1:0]),   32'(mon_e[CW-1:0]));
          check("word_timeout", 32'(mon_w[CW]),       32'(mon_e[CW]));
        end
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held_w = mon_w;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a falling edge; returns at slot 1.
  task automatic start_run();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Sensor 0 high from slot rise0 and during [g_lo, g_hi]; sensor 1 from rise1.
  task automatic drive(input int n, input int rise0, input int rise1,
                       input int g_lo, input int g_hi);
    for (int s = 1; s <= n; s++) begin
      sensor[0] = (s >= rise0) || (s >= g_lo && s <= g_hi);
      sensor[1] = (s >= rise1);
      tick(1);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 5000) begin
      tick(1);
      k++;
    end
    if (k >= 5000) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_done: busy=%0d pending=%0d after %0d cycles, expected drained",
               busy, exp_q.size(), k);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic quiet(input int n);
    sensor = '0;
    tick(n);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    32'(busy),               32'd0);
    check({tag, "_valid"},   32'(rif.result_valid),   32'd0);
    check({tag, "_channel"}, 32'(rif.result_channel), 32'd0);
    check({tag, "_cycles"},  32'(rif.result_cycles),  32'd0);
    check({tag, "_timeout"}, 32'(rif.result_timeout), 32'd0);
    check({tag, "_led"},     32'(led),                32'd0);
    check({tag, "_state"},   32'(dbg_state),          32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rif.result_ready = 1'b1;
    tick(2);
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(3);

`ifdef LAG_METER_AVERAGE_EN
    // Four runs, ch0 lags 10..13 (avg 11), ch1 lags 20 every run.
    push_exp(0, 11, 1'b0);
    push_exp(1, 20, 1'b0);
    for (int r = 0; r < 4; r++) begin
      start_run();
      drive(40, 10 + r, 20, 0, -1);
      sensor = '0;
      if (r < 3) begin
        check("avg_gap_busy",  32'(busy),      32'd1);
        check("avg_gap_state", 32'(dbg_state), 32'd0);
        check("avg_gap_valid", 32'(rif.result_valid), 32'd0);
      end
      tick(10);
    end
    wait_done();
`else
    // 1: clean edges at 10 and 250.
    push_exp(0, 10, 1'b0);
    push_exp(1, 250, 1'b0);
    start_run();
    check("s1_busy_after_start", 32'(busy), 32'd1);
    drive(260, 10, 250, 0, -1);
    check("s1_led_both_high", 32'(led), 32'd3);
    wait_done();
    quiet(10);
    check("s1_led_low", 32'(led), 32'd0);

    // 2: ch0 glitch at 50..51, clean rise at 80; ch1 at 120.
    push_exp(0, 80, 1'b0);
    push_exp(1, 120, 1'b0);
    start_run();
    drive(140, 80, 120, 50, 51);
    wait_done();
    quiet(10);

    // 3: ch1 stuck high from before start -> timeout; ch0 at 30.
    sensor[1] = 1'b1;
    tick(10);
    push_exp(0, 30, 1'b0);
    push_exp(1, MAXC, 1'b1);
    start_run();
    drive(MAXC, 30, 0, 0, -1);
    check("s3_valid_low_at_max",   32'(rif.result_valid), 32'd0);
    check("s3_busy_at_max",        32'(busy),             32'd1);
    tick(1);
    check("s3_valid_one_after_max", 32'(rif.result_valid), 32'd1);
    wait_done();
    quiet(10);

    // 4: stalled consumer, start ignored in REPORT and on the return edge.
    rif.result_ready = 1'b0;
    push_exp(0, 20, 1'b0);
    push_exp(1, 40, 1'b0);
    start_run();
    drive(60, 20, 40, 0, -1);
    check("s4_valid_stalled", 32'(rif.result_valid), 32'd1);
    start_run();
    tick(3);
    check("s4_state_report",   32'(dbg_state),          32'd2);
    check("s4_channel_held",   32'(rif.result_channel), 32'd0);
    check("s4_cycles_held",    32'(rif.result_cycles),  32'd20);
    rif.result_ready = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("s4_idle_after_last", 32'(dbg_state), 32'd0);
    tick(2);
    check("s4_start_ignored_busy", 32'(busy), 32'd0);
    wait_done();
    quiet(10);

    // 5: reset mid-MEASURE, with start held during reset, then a fresh run.
    start_run();
    drive(100, 20, NEVER, 0, -1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    start = 1'b1;
    sensor = '0;
    tick(2);
    check("reset_beats_start", 32'(busy), 32'd0);
    start = 1'b0;
    reset_n = 1'b1;
    tick(10);
    push_exp(0, 15, 1'b0);
    push_exp(1, 33, 1'b0);
    start_run();
    drive(60, 15, 33, 0, -1);
    wait_done();
    quiet(5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
